counter_share_ctrl: RTL and testbench

COUNTER_SHARE_CTRL -- requirements
Module: counter_share_ctrl

---
 rtl/counter_share_ctrl.sv | 87 ++++++++
 tb/tb_counter_share_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/counter_share_ctrl.sv
// Shared counter with two round-robin incrementers, a settle/load
// start-up sequence, and a registered wrap pulse.
module counter_share_ctrl #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] INIT_VAL    = 4'b1010,
    parameter int               INIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic             clr,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             init_done
);

    typedef enum logic [1:0] {
        S_WAIT,
        S_LOAD,
        S_RUN
    } state_t;

    state_t           state, state_nx;
    logic [3:0]       settle, settle_nx;
    logic [WIDTH-1:0] count_nx;
    logic [1:0]       gnt_nx;
    logic             wrap_nx;
    logic             prio, prio_nx;
    logic             winner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_WAIT;
            settle <= '0;
            count  <= '0;
            gnt    <= '0;
            wrap   <= 1'b0;
            prio   <= 1'b0;
        end else begin
            state  <= state_nx;
            settle <= settle_nx;
            count  <= count_nx;
            gnt    <= gnt_nx;
            wrap   <= wrap_nx;
            prio   <= prio_nx;
        end
    end

    // prio names the requester that wins the next tie
    always_comb begin
        state_nx  = state;
        settle_nx = settle;
        count_nx  = count;
        gnt_nx    = 2'b00;
        wrap_nx   = 1'b0;
        prio_nx   = prio;
        winner    = 1'b0;
        unique case (state)
            S_WAIT: begin
                if (settle == 4'(INIT_CYCLES - 1))
                    state_nx = S_LOAD;
                else
                    settle_nx = settle + 4'd1;
            end
            S_LOAD: begin
                count_nx = INIT_VAL;
                state_nx = S_RUN;
            end
            S_RUN: begin
                if (clr) begin
                    count_nx = INIT_VAL;
                end else if (req != 2'b00) begin
                    winner   = (req == 2'b11) ? prio : req[1];
                    gnt_nx   = winner ? 2'b10 : 2'b01;
                    count_nx = count + WIDTH'(1);
                    wrap_nx  = &count;
                    prio_nx  = ~winner;
                end
            end
            default: state_nx = S_WAIT;
        endcase
    end

    assign init_done = (state == S_RUN);

endmodule

// File: tb/tb_counter_share_ctrl.sv
// Self-checking bench for counter_share_ctrl: directed start-up, arbitration,
// wrap, clear and async-reset steps plus a randomized run against a model.
module tb_counter_share_ctrl;

    localparam int W    = 4;
    localparam int INIT = 10;
    localparam int IC   = 2;
    localparam int MOD  = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req;
    logic         clr;
    logic [1:0]   gnt;
    logic [W-1:0] count;
    logic         wrap;
    logic         init_done;

    int n_vec = 0;
    int n_err = 0;

    // reference model: edges since reset release, plain integer counter
    int m_edges;
    int m_count;
    int m_gnt;
    int m_wrap;
    int m_tie;

    counter_share_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .clr(clr),
        .gnt(gnt),
        .count(count),
        .wrap(wrap),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_edges = 0;
        m_count = 0;
        m_gnt   = 0;
        m_wrap  = 0;
        m_tie   = 0;
    endtask

    task automatic model_edge(input logic [1:0] r, input logic c);
        int w;
        m_gnt  = 0;
        m_wrap = 0;
        if (m_edges == IC) begin
            m_count = INIT;
        end else if (m_edges > IC) begin
            if (c) begin
                m_count = INIT;
            end else if (r != 2'b00) begin
                if (r == 2'b11) w = m_tie;
                else w = r[1] ? 1 : 0;
                m_gnt   = 1 << w;
                m_wrap  = (m_count == MOD - 1) ? 1 : 0;
                m_count = (m_count + 1) % MOD;
                m_tie   = 1 - w;
            end
        end
        m_edges++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".gnt"}, int'(gnt), m_gnt);
        chk({tag, ".count"}, int'(count), m_count);
        chk({tag, ".wrap"}, int'(wrap), m_wrap);
        chk({tag, ".init"}, int'(init_done), (m_edges > IC) ? 1 : 0);
    endtask

    task automatic step(input logic [1:0] r, input logic c, input string tag);
        req = r;
        clr = c;
        model_edge(r, c);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        req   = 2'b00;
        clr   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all("rst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) step(2'b11, 1'b0, "startup");
        chk("startup.val", int'(count), 10);
        for (int i = 0; i < 4; i++) step(2'b11, 1'b0, "tie");
        chk("tie.end", int'(count), 14);
        for (int i = 0; i < 3; i++) step(2'b01, 1'b0, "wrap");
        step(2'b10, 1'b0, "pre_clr");
        step(2'b10, 1'b0, "pre_clr");
        chk("pre_clr.val", int'(count), 3);
        step(2'b10, 1'b1, "clr");
        step(2'b11, 1'b0, "post_clr_tie");
        for (int i = 0; i < 5; i++) step(2'b00, 1'b0, "idle");

        for (int i = 0; i < 300; i++) begin
            logic [1:0] r;
            logic c;
            r = 2'($urandom_range(0, 3));
            c = ($urandom_range(0, 15) == 0);
            step(r, c, "rand");
        end

        k = 0;
        while (m_count != 7 && k < 20) begin
            step(2'b01, 1'b0, "to7");
            k++;
        end
        chk("to7.val", int'(count), 7);

        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(2'b11, 1'b0, "restart");
        chk("restart.val", int'(count), 10);
        step(2'b11, 1'b0, "restart_tie");
        chk("restart_tie.gnt", int'(gnt), 1);

        for (int i = 0; i < 100; i++) begin
            logic [1:0] r;
            r = 2'($urandom_range(0, 3));
            step(r, 1'b0, "rand2");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
